if_fetch_controller: RTL and testbench

IF_FETCH_CONTROLLER -- requirements
Module: if_fetch_controller

---
 rtl/if_fetch_controller.sv | 189 ++++++++++++++++++
 tb/tb_if_fetch_controller.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/if_fetch_controller.sv
`default_nettype none
// ============================================================================
// Module   : if_fetch_controller
// Brief    : Instruction-fetch sequencer sharing one memory port between
//            fetch reads and program-loader writes, with stall and redirect.
// Revision : 1.0
// ============================================================================
module if_fetch_controller #(
    parameter int WORD_LEN    = 32,
    parameter int ADDRESS_LEN = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   freeze,
    input  logic                   branch_taken,
    input  logic [ADDRESS_LEN-1:0] branch_address,
    input  logic                   ld_req,
    input  logic [ADDRESS_LEN-1:0] ld_addr,
    input  logic [WORD_LEN-1:0]    ld_data,
    output logic                   ld_gnt,
    output logic                   mem_req,
    output logic                   mem_we,
    output logic [ADDRESS_LEN-1:0] mem_addr,
    output logic [WORD_LEN-1:0]    mem_wdata,
    input  logic [WORD_LEN-1:0]    mem_rdata,
    input  logic                   mem_ack,
    output logic [WORD_LEN-1:0]    instruction,
    output logic                   valid,
    output logic [ADDRESS_LEN-1:0] pc
);

    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_FETCH = 2'd1;
    localparam logic [1:0] c_LOAD  = 2'd2;

    localparam logic [ADDRESS_LEN-1:0] c_PC_STEP = ADDRESS_LEN'(4);

    logic [1:0]             r_state;
    logic [1:0]             w_state_nxt;
    logic [ADDRESS_LEN-1:0] r_pc_reg;
    logic                   r_discard;
    logic                   r_ld_gnt;
    logic                   r_mem_req;
    logic                   r_mem_we;
    logic [ADDRESS_LEN-1:0] r_mem_addr;
    logic [WORD_LEN-1:0]    r_mem_wdata;
    logic [WORD_LEN-1:0]    r_instruction;
    logic                   r_valid;
    logic [ADDRESS_LEN-1:0] r_pc;

    logic                   w_ack_fetch;
    logic                   w_ack_load;
    logic                   w_capture;
    logic                   w_start_load;
    logic                   w_start_fetch;
    logic [ADDRESS_LEN-1:0] w_branch_target;
    logic [ADDRESS_LEN-1:0] w_ld_addr_aligned;
    logic [ADDRESS_LEN-1:0] w_fetch_addr;
    logic [ADDRESS_LEN-1:0] w_pc_inc;
    logic                   w_unused_lsbs;

    assign w_branch_target   = {branch_address[ADDRESS_LEN-1:2], 2'b00};
    assign w_ld_addr_aligned = {ld_addr[ADDRESS_LEN-1:2], 2'b00};
    assign w_unused_lsbs     = ^{branch_address[1:0], ld_addr[1:0]};
    assign w_pc_inc          = r_pc_reg + c_PC_STEP;

    assign w_ack_fetch = (r_state == c_FETCH) && mem_ack;
    assign w_ack_load  = (r_state == c_LOAD) && mem_ack;
    assign w_capture   = w_ack_fetch && !r_discard && !branch_taken;

    // A redirect seen in IDLE fetches straight from the target, so no stale
    // word is ever requested and no discard is needed.
    assign w_fetch_addr = branch_taken ? w_branch_target : r_pc_reg;

    // The grant cycle still sees the loader's held request; ignore it then.
    assign w_start_load  = (r_state == c_IDLE) && ld_req && !r_ld_gnt;
    assign w_start_fetch = (r_state == c_IDLE) && !w_start_load &&
                           (!(r_valid && freeze) || branch_taken);

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_IDLE: begin
                if (w_start_load) begin
                    w_state_nxt = c_LOAD;
                end else if (w_start_fetch) begin
                    w_state_nxt = c_FETCH;
                end
            end
            c_FETCH: begin
                if (mem_ack) begin
                    w_state_nxt = c_IDLE;
                end
            end
            c_LOAD: begin
                if (mem_ack) begin
                    w_state_nxt = c_IDLE;
                end
            end
            default: begin
                w_state_nxt = c_IDLE;
            end
        endcase
    end

    // Memory port registers: request/address/data launch on leaving IDLE and
    // stay put until the acknowledge, so nothing depends combinationally on mem_ack.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_ld_gnt    <= 1'b0;
        end else begin
            r_ld_gnt <= w_ack_load;
            if (w_start_load) begin
                r_mem_req   <= 1'b1;
                r_mem_we    <= 1'b1;
                r_mem_addr  <= w_ld_addr_aligned;
                r_mem_wdata <= ld_data;
            end else if (w_start_fetch) begin
                r_mem_req  <= 1'b1;
                r_mem_we   <= 1'b0;
                r_mem_addr <= w_fetch_addr;
            end else if (w_ack_fetch || w_ack_load) begin
                r_mem_req <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_pc_reg  <= '0;
            r_discard <= 1'b0;
        end else begin
            if (branch_taken) begin
                r_pc_reg <= w_branch_target;
            end else if (w_capture) begin
                r_pc_reg <= w_pc_inc;
            end

            if (w_ack_fetch) begin
                r_discard <= 1'b0;
            end else if ((r_state == c_FETCH) && branch_taken) begin
                r_discard <= 1'b1;
            end
        end
    end

    // IF/ID holding register: a redirect kills it, a capture fills it,
    // otherwise it empties whenever decode is not frozen.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_instruction <= '0;
            r_valid       <= 1'b0;
            r_pc          <= '0;
        end else begin
            if (branch_taken) begin
                r_valid <= 1'b0;
            end else if (w_capture) begin
                r_valid       <= 1'b1;
                r_instruction <= mem_rdata;
                r_pc          <= w_pc_inc;
            end else if (!freeze) begin
                r_valid <= 1'b0;
            end
        end
    end

    assign ld_gnt      = r_ld_gnt;
    assign mem_req     = r_mem_req;
    assign mem_we      = r_mem_we;
    assign mem_addr    = r_mem_addr;
    assign mem_wdata   = r_mem_wdata;
    assign instruction = r_instruction;
    assign valid       = r_valid;
    assign pc          = r_pc;

endmodule
`default_nettype wire

// File: tb/tb_if_fetch_controller.sv
`default_nettype none
// ============================================================================
// Module   : tb_if_fetch_controller
// Brief    : Directed bench for if_fetch_controller with a latency-programmable
//            memory responder.
// Revision : 1.0
// ============================================================================
module tb_if_fetch_controller;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        freeze = 1'b0;
    logic        branch_taken = 1'b0;
    logic [31:0] branch_address = '0;
    logic        ld_req = 1'b0;
    logic [31:0] ld_addr = '0;
    logic [31:0] ld_data = '0;
    logic        ld_gnt;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ack;
    logic [31:0] instruction;
    logic        valid;
    logic [31:0] pc;

    logic        resp_en = 1'b1;
    logic        resp_ack = 1'b0;
    logic [31:0] resp_rdata = '0;
    int          lat = 1;
    int          resp_cnt = 0;
    logic        man_ack = 1'b0;
    logic [31:0] man_rdata = '0;
    logic        sp_en = 1'b0;
    logic [31:0] sp_addr = '0;
    logic [31:0] sp_data = '0;
    logic [31:0] log_addr[$];
    logic        log_we[$];

    int vecs = 0;
    int miss = 0;
    int cyc  = 0;

    assign mem_ack   = resp_ack | man_ack;
    assign mem_rdata = man_ack ? man_rdata : resp_rdata;

    if_fetch_controller #(.WORD_LEN(32), .ADDRESS_LEN(32)) dut (
        .clk(clk), .rst(rst), .freeze(freeze),
        .branch_taken(branch_taken), .branch_address(branch_address),
        .ld_req(ld_req), .ld_addr(ld_addr), .ld_data(ld_data), .ld_gnt(ld_gnt),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
        .instruction(instruction), .valid(valid), .pc(pc)
    );

    initial forever #5 clk = ~clk;

    // Memory: reads return the word index unless the special address matches.
    initial forever begin
        @(negedge clk);
        if (!rst || !resp_en) begin
            resp_ack = 1'b0;
            resp_cnt = 0;
        end else if (resp_ack) begin
            resp_ack = 1'b0;
            resp_cnt = 0;
        end else if (mem_req) begin
            if (resp_cnt == 0) begin
                log_addr.push_back(mem_addr);
                log_we.push_back(mem_we);
            end
            resp_cnt++;
            if (resp_cnt >= lat) begin
                resp_ack   = 1'b1;
                resp_rdata = (sp_en && mem_addr == sp_addr) ? sp_data : (mem_addr >> 2);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(negedge clk);
        cyc++;
    endtask

    task automatic wait_valid(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (valid) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        log_addr.delete();
        log_we.delete();
        rst = 1'b0;
        tick();
        tick();
        vecs++; if (mem_req !== 1'b0) begin miss++; $display("FAIL rst_mem_req actual=%b required=0", mem_req); end
        vecs++; if (mem_we !== 1'b0) begin miss++; $display("FAIL rst_mem_we actual=%b required=0", mem_we); end
        vecs++; if (mem_addr !== 32'h0) begin miss++; $display("FAIL rst_mem_addr actual=%h required=0", mem_addr); end
        vecs++; if (mem_wdata !== 32'h0) begin miss++; $display("FAIL rst_mem_wdata actual=%h required=0", mem_wdata); end
        vecs++; if (valid !== 1'b0) begin miss++; $display("FAIL rst_valid actual=%b required=0", valid); end
        vecs++; if (instruction !== 32'h0) begin miss++; $display("FAIL rst_instr actual=%h required=0", instruction); end
        vecs++; if (pc !== 32'h0) begin miss++; $display("FAIL rst_pc actual=%h required=0", pc); end
        vecs++; if (ld_gnt !== 1'b0) begin miss++; $display("FAIL rst_ld_gnt actual=%b required=0", ld_gnt); end
        rst = 1'b1;
    endtask

    task automatic test_sequential();
        bit ok;
        int last_cyc;
        lat = 1;
        last_cyc = 0;
        for (int k = 0; k < 3; k++) begin
            wait_valid(ok);
            vecs++; if (ok !== 1'b1) begin miss++; $display("FAIL seq_valid%0d timeout actual=0 required=1", k); end
            vecs++; if (instruction !== 32'(k)) begin miss++; $display("FAIL seq_instr%0d actual=%h required=%h", k, instruction, 32'(k)); end
            vecs++; if (pc !== 32'(4 * (k + 1))) begin miss++; $display("FAIL seq_pc%0d actual=%h required=%h", k, pc, 32'(4 * (k + 1))); end
            if (k > 0) begin
                vecs++; if (cyc - last_cyc !== 2) begin miss++; $display("FAIL seq_rate%0d actual=%0d required=2", k, cyc - last_cyc); end
            end
            last_cyc = cyc;
        end
        for (int k = 0; k < 3; k++) begin
            vecs++;
            if (log_addr.size() <= k || log_addr[k] !== 32'(4 * k) || log_we[k] !== 1'b0) begin
                miss++;
                $display("FAIL seq_issue%0d actual=%h required=%h (read)", k,
                         (log_addr.size() > k) ? log_addr[k] : 32'hxxxxxxxx, 32'(4 * k));
            end
        end
        // Next fetch (address 0xC) returns a recognisable opcode.
        sp_en   = 1'b1;
        sp_addr = 32'h0000_000C;
        sp_data = 32'hE3A0_0014;
    endtask

    task automatic test_freeze();
        bit ok;
        wait_valid(ok);
        freeze = 1'b1;
        vecs++; if (ok !== 1'b1) begin miss++; $display("FAIL frz_valid timeout actual=0 required=1"); end
        vecs++; if (instruction !== 32'hE3A0_0014) begin miss++; $display("FAIL frz_instr actual=%h required=e3a00014", instruction); end
        vecs++; if (pc !== 32'h10) begin miss++; $display("FAIL frz_pc actual=%h required=10", pc); end
        for (int i = 0; i < 5; i++) begin
            tick();
            vecs++; if (valid !== 1'b1) begin miss++; $display("FAIL frz_hold_valid%0d actual=%b required=1", i, valid); end
            vecs++; if (instruction !== 32'hE3A0_0014) begin miss++; $display("FAIL frz_hold_instr%0d actual=%h required=e3a00014", i, instruction); end
            vecs++; if (pc !== 32'h10) begin miss++; $display("FAIL frz_hold_pc%0d actual=%h required=10", i, pc); end
            vecs++; if (mem_req !== 1'b0) begin miss++; $display("FAIL frz_hold_req%0d actual=%b required=0", i, mem_req); end
        end
        lat = 3;
        freeze = 1'b0;
        tick();
        vecs++; if (valid !== 1'b0) begin miss++; $display("FAIL frz_release_valid actual=%b required=0", valid); end
        vecs++; if (mem_req !== 1'b1 || mem_we !== 1'b0) begin miss++; $display("FAIL frz_release_req actual=%b/%b required=1/0", mem_req, mem_we); end
        vecs++; if (mem_addr !== 32'h10) begin miss++; $display("FAIL frz_release_addr actual=%h required=10", mem_addr); end
    endtask

    task automatic test_branch();
        bit ok;
        int n;
        branch_taken   = 1'b1;
        branch_address = 32'h0000_0093;
        tick();
        branch_taken = 1'b0;
        vecs++; if (valid !== 1'b0) begin miss++; $display("FAIL br_valid_kill actual=%b required=0", valid); end
        wait_valid(ok);
        vecs++; if (ok !== 1'b1) begin miss++; $display("FAIL br_valid timeout actual=0 required=1"); end
        vecs++; if (pc !== 32'h94) begin miss++; $display("FAIL br_pc actual=%h required=94", pc); end
        vecs++; if (instruction !== 32'h24) begin miss++; $display("FAIL br_instr actual=%h required=24", instruction); end
        n = log_addr.size();
        vecs++;
        if (n < 2 || log_addr[n-2] !== 32'h10 || log_addr[n-1] !== 32'h90) begin
            miss++;
            $display("FAIL br_issue_order actual=%h,%h required=10,90",
                     (n >= 2) ? log_addr[n-2] : 32'hxxxxxxxx, (n >= 1) ? log_addr[n-1] : 32'hxxxxxxxx);
        end
    endtask

    task automatic test_load();
        logic [31:0] a, vpc, waddr, wdata, nf;
        int seen_valid, write_c, gnt_c, gnt_cnt;
        bit got_fetch, got_next;
        lat = 3;
        got_fetch = 1'b0;
        a = '0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (mem_req && !mem_we) begin
                got_fetch = 1'b1;
                a = mem_addr;
                break;
            end
        end
        vecs++; if (got_fetch !== 1'b1) begin miss++; $display("FAIL ld_fetch_inflight timeout actual=0 required=1"); end
        ld_req  = 1'b1;
        ld_addr = 32'h0000_0400;
        ld_data = 32'h0000_2000;
        seen_valid = -1; write_c = -1; gnt_c = -1; gnt_cnt = 0; got_next = 1'b0;
        vpc = 'x; waddr = 'x; wdata = 'x; nf = 'x;
        for (int i = 0; i < 60; i++) begin
            tick();
            if (valid && seen_valid < 0) begin seen_valid = i; vpc = pc; end
            if (mem_req && mem_we && write_c < 0) begin write_c = i; waddr = mem_addr; wdata = mem_wdata; end
            if (gnt_c >= 0 && !got_next && mem_req && !mem_we) begin got_next = 1'b1; nf = mem_addr; end
            if (ld_gnt) begin
                gnt_cnt++;
                if (gnt_c < 0) gnt_c = i;
                ld_req = 1'b0;
            end
        end
        vecs++; if (vpc !== a + 32'd4) begin miss++; $display("FAIL ld_fetch_first_pc actual=%h required=%h", vpc, a + 32'd4); end
        vecs++; if (!(seen_valid >= 0 && write_c > seen_valid)) begin miss++; $display("FAIL ld_order actual=valid@%0d write@%0d required=valid before write", seen_valid, write_c); end
        vecs++; if (waddr !== 32'h400) begin miss++; $display("FAIL ld_addr actual=%h required=400", waddr); end
        vecs++; if (wdata !== 32'h2000) begin miss++; $display("FAIL ld_wdata actual=%h required=2000", wdata); end
        vecs++; if (gnt_cnt !== 1) begin miss++; $display("FAIL ld_gnt_count actual=%0d required=1", gnt_cnt); end
        vecs++; if (nf !== a + 32'd4) begin miss++; $display("FAIL ld_resume_addr actual=%h required=%h", nf, a + 32'd4); end
    endtask

    task automatic test_wrap();
        bit ok;
        lat = 1;
        branch_taken   = 1'b1;
        branch_address = 32'hFFFF_FFFF;
        tick();
        branch_taken = 1'b0;
        wait_valid(ok);
        vecs++; if (ok !== 1'b1) begin miss++; $display("FAIL wrap_valid timeout actual=0 required=1"); end
        vecs++; if (pc !== 32'h0) begin miss++; $display("FAIL wrap_pc actual=%h required=0", pc); end
        vecs++; if (instruction !== 32'h3FFF_FFFF) begin miss++; $display("FAIL wrap_instr actual=%h required=3fffffff", instruction); end
        tick();
        vecs++; if (mem_req !== 1'b1 || mem_addr !== 32'h0) begin miss++; $display("FAIL wrap_next_addr actual=%b/%h required=1/0", mem_req, mem_addr); end
    endtask

    task automatic test_reset_mid();
        bit seen;
        resp_en = 1'b0;
        tick();
        tick();
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (mem_req) begin seen = 1'b1; break; end
        end
        vecs++; if (seen !== 1'b1) begin miss++; $display("FAIL rm_fetch_pending timeout actual=0 required=1"); end
        rst = 1'b0;
        tick();
        vecs++; if (mem_req !== 1'b0) begin miss++; $display("FAIL rm_req_drop actual=%b required=0", mem_req); end
        man_rdata = 32'hDEAD_BEEF;
        man_ack   = 1'b1;
        rst       = 1'b1;
        tick();
        man_ack = 1'b0;
        vecs++; if (valid !== 1'b0) begin miss++; $display("FAIL rm_late_ack_valid actual=%b required=0", valid); end
        vecs++; if (mem_req !== 1'b1 || mem_addr !== 32'h0) begin miss++; $display("FAIL rm_restart actual=%b/%h required=1/0", mem_req, mem_addr); end
        vecs++; if (ld_gnt !== 1'b0) begin miss++; $display("FAIL rm_ld_gnt actual=%b required=0", ld_gnt); end
        man_rdata = 32'h0000_0055;
        man_ack   = 1'b1;
        tick();
        man_ack = 1'b0;
        vecs++; if (valid !== 1'b1 || instruction !== 32'h55) begin miss++; $display("FAIL rm_refetch actual=%b/%h required=1/55", valid, instruction); end
        vecs++; if (pc !== 32'h4) begin miss++; $display("FAIL rm_refetch_pc actual=%h required=4", pc); end
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_freeze();
        test_branch();
        test_load();
        test_wrap();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
        $finish;
    end

endmodule
`default_nettype wire
